gpio_bus_responder: RTL and testbench

Memory-mapped GPIO target that answers the multicycle core's load/store accesses.
- Holds an 8-bit output register driving GPIO_o.
- Synchronises GPIO_i, captures rising-edge events and raises a maskable interrupt.
- Returns read data through a req/ack handshake with configurable wait states.
- Sits between the datapath's address/write-data/write-enable bus and the board pins, beside Memory_system in the address map.

---
 rtl/gpio_bus_pkg.sv | 21 ++
 rtl/gpio_bus_responder_sync_edge.sv | 37 +++
 rtl/gpio_bus_responder.sv | 184 ++++++++++++++++++
 tb/tb_gpio_bus_responder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/gpio_bus_pkg.sv
// Shared constants for the GPIO bus responder: register offsets and FSM encoding.
package gpio_bus_pkg;

  localparam logic [3:0] OFF_OUT  = 4'h0;
  localparam logic [3:0] OFF_IN   = 4'h4;
  localparam logic [3:0] OFF_EDGE = 4'h8;
  localparam logic [3:0] OFF_MASK = 4'hC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    HOLD = 2'd3
  } fsm_state_t;

  // Registers are 8 bits wide; every read is zero-extended onto the 32-bit bus.
  function automatic logic [31:0] zext8(input logic [7:0] value);
    return {24'b0, value};
  endfunction

endpackage

// File: rtl/gpio_bus_responder_sync_edge.sv
// Multi-stage input synchroniser with a one-cycle rising-edge pulse per bit.
module gpio_sync_edge #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise
);

  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  // Oldest sample lives in the top WIDTH bits of the chain.
  logic [STAGES*WIDTH-1:0] chain_reg;
  logic [WIDTH-1:0]        prev_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain_reg <= '0;
      prev_reg  <= '0;
    end else begin
      chain_reg <= {chain_reg[(STAGES-1)*WIDTH-1:0], din};
      prev_reg  <= sync_out;
    end
  end

  assign sync_out = chain_reg[STAGES*WIDTH-1 -: WIDTH];

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rise
      assign rise[gi] = sync_out[gi] & ~prev_reg[gi];
    end
  endgenerate

endmodule

// File: rtl/gpio_bus_responder.sv
// Memory-mapped GPIO target: output latch, synchronised inputs with sticky
// rising-edge flags and a maskable interrupt, behind a req/ack bus with wait states.
module gpio_bus_responder
  import gpio_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_FF00,
  parameter int          WAIT_STATES = 0,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_req,
  input  logic        bus_we,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ack,
  output logic        bus_err,
  input  logic [7:0]  GPIO_i,
  output logic [7:0]  GPIO_o,
  output logic        irq
);

  localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  fsm_state_t  state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic        enter_ack;

  logic [31:0] addr_reg;
  logic        we_reg;
  logic [7:0]  wdata_reg;
  logic [31:0] rdata_reg;
  logic        err_reg;

  logic [7:0]  out_reg, out_next;
  logic [7:0]  mask_reg, mask_next;
  logic [7:0]  edge_flags_reg, edge_flags_next;
  logic [7:0]  edge_clear;
  logic        irq_reg;

  logic [7:0]  sync_in;
  logic [7:0]  rise;

  logic [31:0] cur_addr;
  logic        cur_we;
  logic        cur_ok;
  logic [7:0]  rd_byte;
  logic        commit;

  logic        unused_wdata;
  assign unused_wdata = ^bus_wdata[31:8];

  gpio_sync_edge #(
    .WIDTH       (8),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk      (clk),
    .reset    (reset),
    .din      (GPIO_i),
    .sync_out (sync_in),
    .rise     (rise)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    enter_ack  = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (bus_req) begin
          if (WAIT_STATES > 0) begin
            state_next = WAIT;
            cnt_next   = WAIT_LOAD;
          end else begin
            state_next = ACK;
            enter_ack  = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_reg == 3'd0) begin
          state_next = ACK;
          enter_ack  = 1'b1;
        end else begin
          cnt_next = cnt_reg - 3'd1;
        end
      end
      ACK:  state_next = HOLD;
      // A request left high after its ack is ignored until it drops.
      HOLD: if (!bus_req) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // With no wait states the access is decoded straight off the bus in IDLE.
  assign cur_addr = (state_reg == IDLE) ? bus_addr : addr_reg;
  assign cur_we   = (state_reg == IDLE) ? bus_we   : we_reg;
  assign cur_ok   = (cur_addr[31:4] == BASE_ADDR[31:4]) && (cur_addr[1:0] == 2'b00);

  always_comb begin
    rd_byte = 8'h00;
    case (cur_addr[3:0])
      OFF_OUT:  rd_byte = out_reg;
      OFF_IN:   rd_byte = sync_in;
      OFF_EDGE: rd_byte = edge_flags_reg;
      OFF_MASK: rd_byte = mask_reg;
      default:  rd_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_reg  <= 32'd0;
      we_reg    <= 1'b0;
      wdata_reg <= 8'd0;
      rdata_reg <= 32'd0;
      err_reg   <= 1'b0;
    end else begin
      if (state_reg == IDLE && bus_req) begin
        addr_reg  <= bus_addr;
        we_reg    <= bus_we;
        wdata_reg <= bus_wdata[7:0];
      end
      // Response registers are only non-zero during the single ACK cycle.
      if (enter_ack) begin
        err_reg   <= !cur_ok;
        rdata_reg <= (cur_ok && !cur_we) ? zext8(rd_byte) : 32'd0;
      end else begin
        err_reg   <= 1'b0;
        rdata_reg <= 32'd0;
      end
    end
  end

  assign commit = (state_reg == ACK) && we_reg && !err_reg;

  always_comb begin
    out_next   = out_reg;
    mask_next  = mask_reg;
    edge_clear = 8'h00;
    if (commit) begin
      case (addr_reg[3:0])
        OFF_OUT:  out_next   = wdata_reg;
        OFF_EDGE: edge_clear = wdata_reg;
        OFF_MASK: mask_next  = wdata_reg;
        default:  ;
      endcase
    end
    // A new edge in the same cycle as a W1C clear keeps the flag set.
    edge_flags_next = (edge_flags_reg & ~edge_clear) | rise;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_reg        <= 8'd0;
      mask_reg       <= 8'd0;
      edge_flags_reg <= 8'd0;
      irq_reg        <= 1'b0;
    end else begin
      out_reg        <= out_next;
      mask_reg       <= mask_next;
      edge_flags_reg <= edge_flags_next;
      irq_reg        <= |(edge_flags_reg & mask_reg);
    end
  end

  assign bus_ack   = (state_reg == ACK);
  assign bus_err   = err_reg;
  assign bus_rdata = rdata_reg;
  assign GPIO_o    = out_reg;
  assign irq       = irq_reg;

endmodule

// File: tb/tb_gpio_bus_responder.sv
// Directed bench for gpio_bus_responder: one zero-wait instance and one with three wait states.
module tb_gpio_bus_responder;

  localparam logic [31:0] BASE = 32'h0000_FF00;

  logic        clk = 1'b0;
  logic        reset;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [7:0]  gpio_i;
  logic        sel;

  logic        req0, req3;
  logic [31:0] rdata0, rdata3;
  logic        ack0, ack3, err0, err3, irq0, irq3;
  logic [7:0]  gpio_o0, gpio_o3;

  logic [31:0] rd;
  logic        ack, er, irq_m;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign req0  = bus_req & ~sel;
  assign req3  = bus_req & sel;
  assign ack   = sel ? ack3 : ack0;
  assign rd    = sel ? rdata3 : rdata0;
  assign er    = sel ? err3 : err0;
  assign irq_m = sel ? irq3 : irq0;

  gpio_bus_responder #(.BASE_ADDR(BASE), .WAIT_STATES(0), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .reset(reset), .bus_req(req0), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(rdata0), .bus_ack(ack0), .bus_err(err0),
    .GPIO_i(gpio_i), .GPIO_o(gpio_o0), .irq(irq0)
  );

  gpio_bus_responder #(.BASE_ADDR(BASE), .WAIT_STATES(3), .SYNC_STAGES(2)) dut3 (
    .clk(clk), .reset(reset), .bus_req(req3), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(rdata3), .bus_ack(ack3), .bus_err(err3),
    .GPIO_i(gpio_i), .GPIO_o(gpio_o3), .irq(irq3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
    end
    #1;
  endtask

  // Issues one access, waits (bounded) for the ack, then drops req and returns in IDLE.
  task automatic bus_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            output int lat, output logic [31:0] rdata, output logic err,
                            output logic irq_at);
    lat = -1; rdata = 'x; err = 'x; irq_at = 'x;
    bus_we = we; bus_addr = addr; bus_wdata = wdata; bus_req = 1'b1;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(posedge clk); #1;
      if (ack) begin
        lat = c; rdata = rd; err = er; irq_at = irq_m;
        $display("[TB] %s addr=%h wdata=%h -> rdata=%h err=%0b lat=%0d",
                 we ? "WR" : "RD", addr, wdata, rd, er, c);
      end
    end
    bus_req = 1'b0;
    cycles(2);
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    int l; logic [31:0] d; logic e; logic q;
    bus_access(1'b0, addr, 32'd0, l, d, e, q);
    check({tag, "_lat"}, 32'(l), 32'd1);
    check({tag, "_err"}, {31'd0, e}, 32'd0);
    check({tag, "_data"}, d, exp);
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                          input logic exp_err, output logic irq_at);
    int l; logic [31:0] d; logic e;
    bus_access(1'b1, addr, wd, l, d, e, irq_at);
    check({tag, "_lat"}, 32'(l), 32'd1);
    check({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
  endtask

  initial begin
    int l; int acks; int first;
    logic [31:0] d; logic e; logic q;

    reset = 1'b1; bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
    gpio_i = 8'hA5; sel = 1'b0;
    cycles(3);
    check("rst_gpio_o", {24'd0, gpio_o0}, 32'd0);
    check("rst_ack",    {31'd0, ack0}, 32'd0);
    check("rst_err",    {31'd0, err0}, 32'd0);
    check("rst_rdata",  rdata0, 32'd0);
    check("rst_irq",    {31'd0, irq0}, 32'd0);
    reset = 1'b0;
    cycles(4);

    // 1: IN read, then the edges seen as the synchroniser left reset
    do_read("in_a5", BASE + 32'h4, 32'h0000_00A5);
    do_read("edge_after_rst", BASE + 32'h8, 32'h0000_00A5);

    // 2: OUT write ignores upper bits
    do_write("out_wr", BASE, 32'hDEAD_BE3C, 1'b0, q);
    check("gpio_o_3c", {24'd0, gpio_o0}, 32'h3C);
    do_read("out_rd", BASE, 32'h0000_003C);

    // 3: masked edge raises irq, W1C drops it
    do_write("edge_clr_all", BASE + 32'h8, 32'hFF, 1'b0, q);
    do_read("edge_zero", BASE + 32'h8, 32'h0);
    do_write("mask_wr", BASE + 32'hC, 32'h01, 1'b0, q);
    gpio_i = 8'hA4; cycles(4);
    check("irq_low_no_edge", {31'd0, irq0}, 32'd0);
    gpio_i = 8'hA5; cycles(5);
    check("irq_on_edge", {31'd0, irq0}, 32'd1);
    do_read("edge_bit0", BASE + 32'h8, 32'h01);
    do_write("edge_w1c", BASE + 32'h8, 32'h01, 1'b0, q);
    check("irq_at_ack_before_commit", {31'd0, q}, 32'd1);
    check("irq_after_clear", {31'd0, irq0}, 32'd0);
    do_read("edge_cleared", BASE + 32'h8, 32'h0);

    // 4: W1C coincides with a new edge on the same bit
    gpio_i = 8'hA4; cycles(4);
    gpio_i = 8'hA5; cycles(4);
    check("irq_set_again", {31'd0, irq0}, 32'd1);
    gpio_i = 8'hA4; cycles(4);
    gpio_i = 8'hA5; cycles(1);
    do_write("edge_w1c_race", BASE + 32'h8, 32'h01, 1'b0, q);
    check("irq_race_kept", {31'd0, irq0}, 32'd1);
    do_read("edge_race_kept", BASE + 32'h8, 32'h01);

    // 5: out-of-window and misaligned accesses, plus an ignored IN write
    do_write("miss_wr", BASE + 32'h10, 32'hFF, 1'b1, q);
    check("miss_gpio_o", {24'd0, gpio_o0}, 32'h3C);
    bus_access(1'b0, BASE + 32'h2, 32'd0, l, d, e, q);
    check("misal_rd_lat", 32'(l), 32'd1);
    check("misal_rd_err", {31'd0, e}, 32'd1);
    check("misal_rd_data", d, 32'd0);
    do_write("misal_wr", BASE + 32'h1, 32'hFF, 1'b1, q);
    check("misal_gpio_o", {24'd0, gpio_o0}, 32'h3C);
    do_write("in_wr", BASE + 32'h4, 32'hFF, 1'b0, q);
    check("in_wr_gpio_o", {24'd0, gpio_o0}, 32'h3C);
    do_read("mask_rd", BASE + 32'hC, 32'h01);

    // 6: three wait states, request held for ten cycles
    sel = 1'b1;
    bus_we = 1'b1; bus_addr = BASE; bus_wdata = 32'h0000_005A; bus_req = 1'b1;
    acks = 0; first = -1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (ack) begin
        acks++;
        if (first < 0) first = c;
      end
    end
    bus_req = 1'b0;
    cycles(2);
    $display("[TB] WR held 10 cycles, WAIT_STATES=3 -> acks=%0d first=%0d", acks, first);
    check("ws3_ack_count", 32'(acks), 32'd1);
    check("ws3_latency", 32'(first), 32'd4);
    check("ws3_gpio_o", {24'd0, gpio_o3}, 32'h5A);

    // reset while the FSM sits in WAIT
    bus_we = 1'b0; bus_addr = BASE + 32'h4; bus_req = 1'b1;
    cycles(2);
    check("ws3_no_early_ack", {31'd0, ack3}, 32'd0);
    reset = 1'b1; bus_req = 1'b0;
    cycles(1);
    check("ws3_rst_ack", {31'd0, ack3}, 32'd0);
    check("ws3_rst_rdata", rdata3, 32'd0);
    check("ws3_rst_err", {31'd0, err3}, 32'd0);
    check("ws3_rst_gpio_o", {24'd0, gpio_o3}, 32'd0);
    check("ws3_rst_irq", {31'd0, irq3}, 32'd0);
    reset = 1'b0;
    acks = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (ack3) acks++;
    end
    $display("[TB] reset during WAIT -> acks after reset=%0d", acks);
    check("ws3_abandoned", 32'(acks), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
